seq_core_read: RTL
==================

# seq_core_read

Read stage of the pipelined sequential core, directly upstream of the execute stage. Holds the 8 x D_SIZE general-purpose register file, splits the fetched instruction into opcode, destination and operand fields, and reads or forms the two operands. Registers the result into the r1 pipeline register that drives execute, with stall and flush control from the core's hazard/branch logic.

## Interface
- D_SIZE, 32, data and register width
- A_SIZE, 10, address width; informational, no field uses it
- I_SIZE, 16, instruction width
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- instruction  input  I_SIZE  fetched instruction, valid each cycle
- stall  input  1  hold r1 and ignore instruction
- flush  input  1  load NOP into r1; priority over stall
- wb_write_en  input  1  register file write enable, active 1
- wb_destination  input  3  register file write index
- wb_result  input  D_SIZE  register file write data
- r1_opcode  output  7  registered opcode, = instruction[15:9]
- r1_destination  output  3  registered destination index
- r1_operand_a  output  D_SIZE  registered operand A
- r1_operand_b  output  D_SIZE  registered operand B

## Operation
- Instruction fields: opcode [15:9], rd [8:6], ra [5:3], rb [2:0], imm8 [7:0], off6 [5:0].
- Operand formation, by opcode class and subfield from defines.v:
  - ARITHMETIC, LOGIC, SHIFT_ROTATE: A = R[ra], B = R[rb], destination = rd.
  - LOAD: B = R[rb], A = 0, destination = rd.
  - LOADC: destination = instruction[10:8]; A = R[instruction[10:8]]; B = zero-extended imm8.
  - STORE: A = R[rb] (data), B = R[rd] (address), destination = 0.
  - JMP: B = R[rb]. JMPR: B = sign-extended off6.
  - JMPcond: A = R[rd], B = R[rb]. JMPRcond: A = R[rd], B = sign-extended off6.
  - SPECIAL or unrecognised: A = B = 0, destination = 0.
- Register file: 8 entries, two combinational read ports, one synchronous write port. Write on clk rising edge when wb_write_en = 1. No hardwired-zero register.
- r1 update per rising edge, in priority order:
  - flush = 1: r1_opcode = `NOP (7'b0), destination and operands = 0.
  - stall = 1: all r1 outputs hold.
  - otherwise: r1 loads the decoded fields and operands.
- Register file writes are independent of stall and flush.

## Timing
- Reset: every r1 output = 0, so r1_opcode reads as NOP; all 8 registers = 0. Reset is asynchronous and clears state mid-operation without waiting for a clock edge.
- Latency: instruction to r1 outputs is one clock.
- Register file write to the same-cycle read of that index: governed by FORWARD_EN.
- Write to a different index in the same cycle as a read: the old value is read.
- Simultaneous flush and stall: flush wins.
- Stall with an active wb write: the write completes. The held r1 operand is not refreshed, so forwarding of that write is the hazard unit's job.

## Configuration
- SEQ_CORE_READ_FORWARD_EN defined: write-through bypass on both read ports. When wb_write_en = 1 and wb_destination equals the index being read, the operand takes wb_result in the same cycle.
- Not defined: reads return the pre-write register contents. The hazard unit must stall one extra cycle for a read-after-write on the writeback boundary.

## Structure
- Field position macros join the existing opcode constants in defines.v:
  - SEQ_INSTR_OPCODE, SEQ_INSTR_RD, SEQ_INSTR_RA, SEQ_INSTR_RB, SEQ_INSTR_IMM8, SEQ_INSTR_OFF6.
  - NOP encoding.
- Sub-module seq_core_regs: the register file, with two read ports, one write port and an optional bypass under the same macro.
- Operand muxing and the r1 register live in seq_core_read.

## Test plan
- Reset, then write R3 = 0x0000_0005 and R4 = 0x0000_0007. Issue ADD rd=1, ra=3, rb=4 -> one cycle later r1_operand_a = 5, r1_operand_b = 7, r1_destination = 1.
- R2 = 0xAABB_CC00, then LOADC to R2 with imm8 = 0x3C -> r1_operand_a = 0xAABB_CC00, r1_operand_b = 0x0000_003C, r1_destination = 2.
- JMPR with off6 = 6'b111110 -> r1_operand_b = 0xFFFF_FFFE. JMPRcond with rd = 5 (R5 = 0) -> r1_operand_a = 0.
- Same cycle: wb_write_en = 1 writing R6 = 0x1234 while reading R6. With SEQ_CORE_READ_FORWARD_EN the operand = 0x1234; without it the operand = the old value (0).
- Stall held for 3 cycles while the instruction changes -> r1 unchanged. Assert flush together with stall -> r1_opcode = 0, operands = 0 on the next edge.
- Assert rst_n low between clock edges after the registers have been loaded -> all r1 outputs and all registers read 0 immediately.

Source files
------------

// File: rtl/seq_core_read_pkg.sv
// Shared constants for the sequential core read stage: instruction field positions,
// opcode class encodings and the opcode classifier.
package seq_core_read_pkg;

  localparam int SEQ_A_SIZE   = 10;
  localparam int SEQ_NUM_REGS = 8;

  localparam int SEQ_INSTR_OPCODE_HI   = 15;
  localparam int SEQ_INSTR_OPCODE_LO   = 9;
  localparam int SEQ_INSTR_RD_HI       = 8;
  localparam int SEQ_INSTR_RD_LO       = 6;
  localparam int SEQ_INSTR_RA_HI       = 5;
  localparam int SEQ_INSTR_RA_LO       = 3;
  localparam int SEQ_INSTR_RB_HI       = 2;
  localparam int SEQ_INSTR_RB_LO       = 0;
  localparam int SEQ_INSTR_IMM8_HI     = 7;
  localparam int SEQ_INSTR_IMM8_LO     = 0;
  localparam int SEQ_INSTR_OFF6_HI     = 5;
  localparam int SEQ_INSTR_OFF6_LO     = 0;
  localparam int SEQ_INSTR_LOADC_RD_HI = 10;
  localparam int SEQ_INSTR_LOADC_RD_LO = 8;

  localparam logic [6:0] SEQ_NOP       = 7'b0000000;
  localparam logic [2:0] SEQ_ALU_GROUP = 3'b000;
  localparam logic [4:0] SEQ_LOAD      = 5'b00100;
  localparam logic [4:0] SEQ_LOADC     = 5'b01000;
  localparam logic [4:0] SEQ_STORE     = 5'b00110;
  localparam logic [3:0] SEQ_JMP       = 4'b1000;
  localparam logic [3:0] SEQ_JMPR      = 4'b1100;
  localparam logic [3:0] SEQ_JMPCOND   = 4'b1001;
  localparam logic [3:0] SEQ_JMPRCOND  = 4'b1101;

  typedef enum logic [3:0] {
    CLS_ALU      = 4'd0,
    CLS_LOAD     = 4'd1,
    CLS_LOADC    = 4'd2,
    CLS_STORE    = 4'd3,
    CLS_JMP      = 4'd4,
    CLS_JMPR     = 4'd5,
    CLS_JMPCOND  = 4'd6,
    CLS_JMPRCOND = 4'd7,
    CLS_SPECIAL  = 4'd8
  } op_class_e;

  // Arithmetic, logic and shift/rotate share the 000xxxx group; NOP is excluded.
  function automatic op_class_e seq_op_class(input logic [6:0] opcode);
    op_class_e cls;
    cls = CLS_SPECIAL;
    if ((opcode[6:4] == SEQ_ALU_GROUP) && (opcode != SEQ_NOP)) begin
      cls = CLS_ALU;
    end else if (opcode[6:2] == SEQ_LOAD) begin
      cls = CLS_LOAD;
    end else if (opcode[6:2] == SEQ_LOADC) begin
      cls = CLS_LOADC;
    end else if (opcode[6:2] == SEQ_STORE) begin
      cls = CLS_STORE;
    end else if (opcode[6:3] == SEQ_JMP) begin
      cls = CLS_JMP;
    end else if (opcode[6:3] == SEQ_JMPR) begin
      cls = CLS_JMPR;
    end else if (opcode[6:3] == SEQ_JMPCOND) begin
      cls = CLS_JMPCOND;
    end else if (opcode[6:3] == SEQ_JMPRCOND) begin
      cls = CLS_JMPRCOND;
    end else begin
      cls = CLS_SPECIAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/seq_core_regs.sv
// 8-entry general-purpose register file: two combinational read ports, one write port.
// SEQ_CORE_READ_FORWARD_EN adds a write-through bypass on both read ports.
module seq_core_regs
  import seq_core_read_pkg::*;
#(
  parameter int D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_idx_i,
  input  logic [D_SIZE-1:0] wr_data_i,
  input  logic [2:0]        rd_a_idx_i,
  input  logic [2:0]        rd_b_idx_i,
  output logic [D_SIZE-1:0] rd_a_data_o,
  output logic [D_SIZE-1:0] rd_b_data_o
);

  logic [D_SIZE-1:0] regs_q [SEQ_NUM_REGS];

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQ_NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

`ifdef SEQ_CORE_READ_FORWARD_EN
  // Read ports with same-cycle bypass of the writeback value.
  always_comb begin
    rd_a_data_o = regs_q[rd_a_idx_i];
    rd_b_data_o = regs_q[rd_b_idx_i];
    if (wr_en_i && (wr_idx_i == rd_a_idx_i)) begin
      rd_a_data_o = wr_data_i;
    end else begin
      rd_a_data_o = regs_q[rd_a_idx_i];
    end
    if (wr_en_i && (wr_idx_i == rd_b_idx_i)) begin
      rd_b_data_o = wr_data_i;
    end else begin
      rd_b_data_o = regs_q[rd_b_idx_i];
    end
  end
`else
  // Read ports return the pre-write contents.
  always_comb begin
    rd_a_data_o = regs_q[rd_a_idx_i];
    rd_b_data_o = regs_q[rd_b_idx_i];
  end
`endif

endmodule

// File: rtl/seq_core_read.sv
// Read stage of the sequential core: decodes fields, forms operands, drives the r1 register.
// Optional write-through bypass in the register file under SEQ_CORE_READ_FORWARD_EN.
module seq_core_read
  import seq_core_read_pkg::*;
#(
  parameter int D_SIZE = 32,
  parameter int I_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [I_SIZE-1:0] instruction,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_write_en,
  input  logic [2:0]        wb_destination,
  input  logic [D_SIZE-1:0] wb_result,
  output logic [6:0]        r1_opcode,
  output logic [2:0]        r1_destination,
  output logic [D_SIZE-1:0] r1_operand_a,
  output logic [D_SIZE-1:0] r1_operand_b
);

  logic [6:0]        opcode_s;
  logic [2:0]        rd_s;
  logic [2:0]        ra_s;
  logic [2:0]        rb_s;
  logic [2:0]        loadc_rd_s;
  logic [7:0]        imm8_s;
  logic [5:0]        off6_s;
  op_class_e         cls_s;
  logic [D_SIZE-1:0] imm8_ext_s;
  logic [D_SIZE-1:0] off6_ext_s;

  logic [2:0]        rd_a_idx_s;
  logic [2:0]        rd_b_idx_s;
  logic [D_SIZE-1:0] rd_a_data_s;
  logic [D_SIZE-1:0] rd_b_data_s;

  logic [2:0]        dest_s;
  logic [D_SIZE-1:0] opa_s;
  logic [D_SIZE-1:0] opb_s;

  logic [6:0]        opcode_d,  opcode_q;
  logic [2:0]        dest_d,    dest_q;
  logic [D_SIZE-1:0] opa_d,     opa_q;
  logic [D_SIZE-1:0] opb_d,     opb_q;

  assign opcode_s   = instruction[SEQ_INSTR_OPCODE_HI:SEQ_INSTR_OPCODE_LO];
  assign rd_s       = instruction[SEQ_INSTR_RD_HI:SEQ_INSTR_RD_LO];
  assign ra_s       = instruction[SEQ_INSTR_RA_HI:SEQ_INSTR_RA_LO];
  assign rb_s       = instruction[SEQ_INSTR_RB_HI:SEQ_INSTR_RB_LO];
  assign loadc_rd_s = instruction[SEQ_INSTR_LOADC_RD_HI:SEQ_INSTR_LOADC_RD_LO];
  assign imm8_s     = instruction[SEQ_INSTR_IMM8_HI:SEQ_INSTR_IMM8_LO];
  assign off6_s     = instruction[SEQ_INSTR_OFF6_HI:SEQ_INSTR_OFF6_LO];
  assign cls_s      = seq_op_class(opcode_s);
  assign imm8_ext_s = {{(D_SIZE-8){1'b0}}, imm8_s};
  assign off6_ext_s = {{(D_SIZE-6){off6_s[5]}}, off6_s};

  // Read-port address selection per opcode class.
  always_comb begin
    rd_a_idx_s = ra_s;
    rd_b_idx_s = rb_s;
    case (cls_s)
      CLS_LOADC: begin
        rd_a_idx_s = loadc_rd_s;
      end
      CLS_STORE: begin
        rd_a_idx_s = rb_s;
        rd_b_idx_s = rd_s;
      end
      CLS_JMPCOND, CLS_JMPRCOND: begin
        rd_a_idx_s = rd_s;
      end
      default: begin
        rd_a_idx_s = ra_s;
        rd_b_idx_s = rb_s;
      end
    endcase
  end

  seq_core_regs #(
    .D_SIZE (D_SIZE)
  ) u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wb_write_en),
    .wr_idx_i    (wb_destination),
    .wr_data_i   (wb_result),
    .rd_a_idx_i  (rd_a_idx_s),
    .rd_b_idx_i  (rd_b_idx_s),
    .rd_a_data_o (rd_a_data_s),
    .rd_b_data_o (rd_b_data_s)
  );

  // Operand and destination formation per opcode class.
  always_comb begin
    dest_s = 3'd0;
    opa_s  = '0;
    opb_s  = '0;
    case (cls_s)
      CLS_ALU: begin
        dest_s = rd_s;
        opa_s  = rd_a_data_s;
        opb_s  = rd_b_data_s;
      end
      CLS_LOAD: begin
        dest_s = rd_s;
        opb_s  = rd_b_data_s;
      end
      CLS_LOADC: begin
        dest_s = loadc_rd_s;
        opa_s  = rd_a_data_s;
        opb_s  = imm8_ext_s;
      end
      CLS_STORE: begin
        opa_s  = rd_a_data_s;
        opb_s  = rd_b_data_s;
      end
      CLS_JMP: begin
        opb_s  = rd_b_data_s;
      end
      CLS_JMPR: begin
        opb_s  = off6_ext_s;
      end
      CLS_JMPCOND: begin
        opa_s  = rd_a_data_s;
        opb_s  = rd_b_data_s;
      end
      CLS_JMPRCOND: begin
        opa_s  = rd_a_data_s;
        opb_s  = off6_ext_s;
      end
      default: begin
        dest_s = 3'd0;
        opa_s  = '0;
        opb_s  = '0;
      end
    endcase
  end

  // r1 next state: flush beats stall, stall holds, otherwise load decoded values.
  always_comb begin
    opcode_d = opcode_q;
    dest_d   = dest_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    if (flush) begin
      opcode_d = SEQ_NOP;
      dest_d   = 3'd0;
      opa_d    = '0;
      opb_d    = '0;
    end else if (stall) begin
      opcode_d = opcode_q;
      dest_d   = dest_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
    end else begin
      opcode_d = opcode_s;
      dest_d   = dest_s;
      opa_d    = opa_s;
      opb_d    = opb_s;
    end
  end

  // r1 pipeline register with asynchronous clear to NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= SEQ_NOP;
      dest_q   <= 3'd0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  assign r1_opcode      = opcode_q;
  assign r1_destination = dest_q;
  assign r1_operand_a   = opa_q;
  assign r1_operand_b   = opb_q;

endmodule
